// File: rtl/mem_responder.sv
// mem_responder: memory-side endpoint of the CPU MAR/MDR load-strobe interface.
// Holds MAR, MDR and the unified instruction/data RAM. A rising edge on
// i_ld_mdr starts a read or write. WAIT_CYCLES stretches each access and
// holds o_busy high meanwhile. Strobes that arrive during a stretched access
// are dropped and recorded in the sticky o_ovr flag.
//
// Optional feature: define MEM_PARITY_EN to store an even-parity bit per RAM
// word, check it on every read completion, and expose the sticky o_par_err
// output.
//
// Handshake: the controller asserts level strobes. i_ld_mar loads MAR on every
// idle edge where it is high. i_ld_mdr starts one access per rising edge, and
// only while idle. While o_busy is high the controller must hold its state.
// o_rd_valid pulses for one cycle after MDR has been loaded by a read.
module mem_responder #(
    parameter int AW          = 4,
    parameter int DW          = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_ld_mar,
    input  logic [AW-1:0] i_addr,
    input  logic          i_ld_mdr,
    input  logic          i_we,
    input  logic [DW-1:0] i_wdata,
    output logic [AW-1:0] o_mar,
    output logic [DW-1:0] o_mdr,
    output logic          o_busy,
    output logic          o_rd_valid,
    output logic          o_ovr
`ifdef MEM_PARITY_EN
    ,
    output logic          o_par_err
`endif
);

    localparam int         DEPTH       = 1 << AW;
    // The counter is loaded with WAIT_CYCLES-1 so that completion lands
    // exactly WAIT_CYCLES edges after the start edge.
    localparam logic [3:0] LP_CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam bit         LP_HAS_WAIT = (WAIT_CYCLES != 0);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [DW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_mar;
    logic [DW-1:0]   r_mdr;
    logic            r_rd_valid;
    logic            r_ovr;
    logic            r_ld_mdr_q;
    logic [3:0]      r_cnt;
    logic [AW-1:0]   r_acc_addr;
    logic            r_acc_we;
    logic [DW-1:0]   r_acc_wdata;

    logic            w_start;
    logic            w_busy_strobe;
    logic [AW-1:0]   w_eff_addr;
    logic            w_done;
    logic [AW-1:0]   w_cmp_addr;
    logic            w_cmp_we;
    logic [DW-1:0]   w_cmp_wdata;
    logic [DW-1:0]   w_rd_data;

`ifdef MEM_PARITY_EN
    logic            r_par [DEPTH];
    logic            r_par_err;
    logic            w_par_bad;
`endif

    // A start needs a fresh rising edge of the strobe and an idle FSM;
    // a level-held strobe therefore never retriggers.
    assign w_start       = i_ld_mdr && !r_ld_mdr_q && (r_state == S_IDLE);

    // Any strobe seen while stretching an access is dropped and flagged.
    assign w_busy_strobe = (r_state == S_WAIT) && (i_ld_mar || (i_ld_mdr && !r_ld_mdr_q));

    // Pick the address/direction/data of the access that completes this edge.
    always_comb begin
        // A same-edge MAR load bypasses straight into the starting access.
        w_eff_addr  = i_ld_mar ? i_addr : r_mar;
        w_done      = 1'b0;
        w_cmp_addr  = w_eff_addr;
        w_cmp_we    = i_we;
        w_cmp_wdata = i_wdata;
        if (LP_HAS_WAIT) begin
            w_done      = (r_state == S_WAIT) && (r_cnt == '0);
            w_cmp_addr  = r_acc_addr;
            w_cmp_we    = r_acc_we;
            w_cmp_wdata = r_acc_wdata;
        end else begin
            w_done      = w_start;
        end
    end

    assign w_rd_data = r_mem[w_cmp_addr];

`ifdef MEM_PARITY_EN
    // The stored bit makes the word plus parity carry an even number of ones.
    assign w_par_bad = ((^w_rd_data) != r_par[w_cmp_addr]);
`endif

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: only stretched accesses ever leave IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start && LP_HAS_WAIT) w_state_nxt = S_WAIT;
            S_WAIT:  if (r_cnt == '0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: busy exactly while stretching an access.
    always_comb begin
        o_busy = (r_state == S_WAIT);
    end

    // MAR, MDR, strobe history, access latch, counter and status flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mar       <= '0;
            r_mdr       <= '0;
            r_rd_valid  <= 1'b0;
            r_ovr       <= 1'b0;
            r_ld_mdr_q  <= 1'b0;
            r_cnt       <= '0;
            r_acc_addr  <= '0;
            r_acc_we    <= 1'b0;
            r_acc_wdata <= '0;
`ifdef MEM_PARITY_EN
            r_par_err   <= 1'b0;
`endif
        end else begin
            r_ld_mdr_q <= i_ld_mdr;
            r_rd_valid <= 1'b0;

            if ((r_state == S_IDLE) && i_ld_mar) begin
                r_mar <= i_addr;
            end

            if (w_start && LP_HAS_WAIT) begin
                r_acc_addr  <= w_eff_addr;
                r_acc_we    <= i_we;
                r_acc_wdata <= i_wdata;
                r_cnt       <= LP_CNT_INIT;
            end

            if ((r_state == S_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_busy_strobe) begin
                r_ovr <= 1'b1;
            end

            if (w_done) begin
                if (w_cmp_we) begin
                    r_mdr <= w_cmp_wdata;
                end else begin
                    r_mdr      <= w_rd_data;
                    r_rd_valid <= 1'b1;
`ifdef MEM_PARITY_EN
                    if (w_par_bad) begin
                        r_par_err <= 1'b1;
                    end
`endif
                end
            end
        end
    end

    // RAM write port; contents survive reset and a reset edge cancels a write.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_done && w_cmp_we) begin
            r_mem[w_cmp_addr] <= w_cmp_wdata;
`ifdef MEM_PARITY_EN
            r_par[w_cmp_addr] <= ^w_cmp_wdata;
`endif
        end
    end

    assign o_mar      = r_mar;
    assign o_mdr      = r_mdr;
    assign o_rd_valid = r_rd_valid;
    assign o_ovr      = r_ovr;
`ifdef MEM_PARITY_EN
    assign o_par_err  = r_par_err;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: three instances with WAIT_CYCLES = 0, 2 and 3,
// each driven by its own set of inputs. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_mem_responder;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst      [3];
    logic          ld_mar   [3];
    logic [AW-1:0] addr     [3];
    logic          ld_mdr   [3];
    logic          we       [3];
    logic [DW-1:0] wdata    [3];
    logic [AW-1:0] mar      [3];
    logic [DW-1:0] mdr      [3];
    logic          busy     [3];
    logic          rd_valid [3];
    logic          ovr      [3];
`ifdef MEM_PARITY_EN
    logic          par_err  [3];
`endif

    int checks   = 0;
    int failures = 0;

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    mem_responder #(.AW(AW), .DW(DW), .WAIT_CYCLES(0)) u_w0 (
        .i_clk(clk), .i_rst(rst[0]), .i_ld_mar(ld_mar[0]), .i_addr(addr[0]),
        .i_ld_mdr(ld_mdr[0]), .i_we(we[0]), .i_wdata(wdata[0]),
        .o_mar(mar[0]), .o_mdr(mdr[0]), .o_busy(busy[0]),
        .o_rd_valid(rd_valid[0]), .o_ovr(ovr[0])
`ifdef MEM_PARITY_EN
        , .o_par_err(par_err[0])
`endif
    );

    mem_responder #(.AW(AW), .DW(DW), .WAIT_CYCLES(2)) u_w2 (
        .i_clk(clk), .i_rst(rst[1]), .i_ld_mar(ld_mar[1]), .i_addr(addr[1]),
        .i_ld_mdr(ld_mdr[1]), .i_we(we[1]), .i_wdata(wdata[1]),
        .o_mar(mar[1]), .o_mdr(mdr[1]), .o_busy(busy[1]),
        .o_rd_valid(rd_valid[1]), .o_ovr(ovr[1])
`ifdef MEM_PARITY_EN
        , .o_par_err(par_err[1])
`endif
    );

    mem_responder #(.AW(AW), .DW(DW), .WAIT_CYCLES(3)) u_w3 (
        .i_clk(clk), .i_rst(rst[2]), .i_ld_mar(ld_mar[2]), .i_addr(addr[2]),
        .i_ld_mdr(ld_mdr[2]), .i_we(we[2]), .i_wdata(wdata[2]),
        .o_mar(mar[2]), .o_mdr(mdr[2]), .o_busy(busy[2]),
        .o_rd_valid(rd_valid[2]), .o_ovr(ovr[2])
`ifdef MEM_PARITY_EN
        , .o_par_err(par_err[2])
`endif
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_mar(input int k, input logic [AW-1:0] a);
        ld_mar[k] = 1'b1;
        addr[k]   = a;
        tick();
        ld_mar[k] = 1'b0;
    endtask

    // Raise ld_mdr for one cycle, then wait out o_busy. Returns on the
    // falling edge right after the completion edge.
    task automatic access(input int k, input logic w, input logic [DW-1:0] d,
                          output int busy_n, output bit timed_out);
        ld_mdr[k] = 1'b1;
        we[k]     = w;
        wdata[k]  = d;
        tick();
        ld_mdr[k] = 1'b0;
        we[k]     = 1'b0;
        busy_n    = 0;
        timed_out = 1'b0;
        while (busy[k] === 1'b1) begin
            busy_n++;
            if (busy_n > 40) begin
                timed_out = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; ld_mar[k] = 1'b0; addr[k] = '0;
            ld_mdr[k] = 1'b0; we[k] = 1'b0; wdata[k] = '0;
        end
        tick();
        tick();
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (mar[k] !== '0) begin failures++; $display("FAIL reset_mar[%0d] got=%h exp=0", k, mar[k]); end
            checks++; if (mdr[k] !== '0) begin failures++; $display("FAIL reset_mdr[%0d] got=%h exp=0", k, mdr[k]); end
            checks++; if (busy[k] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d] got=%b exp=0", k, busy[k]); end
            checks++; if (rd_valid[k] !== 1'b0) begin failures++; $display("FAIL reset_rdv[%0d] got=%b exp=0", k, rd_valid[k]); end
            checks++; if (ovr[k] !== 1'b0) begin failures++; $display("FAIL reset_ovr[%0d] got=%b exp=0", k, ovr[k]); end
        end
    endtask

    task automatic test_read_w0();
        int n; bit to;
        load_mar(0, 4'd3);
        access(0, 1'b1, 8'hA5, n, to);
        checks++; if (mdr[0] !== 8'hA5) begin failures++; $display("FAIL w0_wr_mdr got=%h exp=a5", mdr[0]); end
        checks++; if (rd_valid[0] !== 1'b0) begin failures++; $display("FAIL w0_wr_rdv got=%b exp=0", rd_valid[0]); end
        load_mar(0, 4'd4);
        access(0, 1'b1, 8'h5A, n, to);
        load_mar(0, 4'd3);
        checks++; if (mar[0] !== 4'd3) begin failures++; $display("FAIL w0_mar got=%h exp=3", mar[0]); end
        access(0, 1'b0, 8'h00, n, to);
        checks++; if (mdr[0] !== 8'hA5) begin failures++; $display("FAIL w0_rd_mdr got=%h exp=a5", mdr[0]); end
        checks++; if (rd_valid[0] !== 1'b1) begin failures++; $display("FAIL w0_rd_rdv got=%b exp=1", rd_valid[0]); end
        checks++; if (n != 0) begin failures++; $display("FAIL w0_busy_cycles got=%0d exp=0", n); end
        tick();
        checks++; if (rd_valid[0] !== 1'b0) begin failures++; $display("FAIL w0_rdv_drop got=%b exp=0", rd_valid[0]); end
    endtask

    task automatic test_write_wait2();
        int n; bit to;
        load_mar(1, 4'd7);
        access(1, 1'b1, 8'h3C, n, to);
        checks++; if (to || n != 2) begin failures++; $display("FAIL w2_wr_busy got=%0d exp=2", n); end
        checks++; if (mdr[1] !== 8'h3C) begin failures++; $display("FAIL w2_wr_mdr got=%h exp=3c", mdr[1]); end
        checks++; if (rd_valid[1] !== 1'b0) begin failures++; $display("FAIL w2_wr_rdv got=%b exp=0", rd_valid[1]); end
        load_mar(1, 4'd8);
        access(1, 1'b1, 8'h77, n, to);
        checks++; if (mdr[1] !== 8'h77) begin failures++; $display("FAIL w2_wr2_mdr got=%h exp=77", mdr[1]); end
        load_mar(1, 4'd7);
        access(1, 1'b0, 8'h00, n, to);
        checks++; if (to || n != 2) begin failures++; $display("FAIL w2_rd_busy got=%0d exp=2", n); end
        checks++; if (mdr[1] !== 8'h3C) begin failures++; $display("FAIL w2_rd_mdr got=%h exp=3c", mdr[1]); end
        checks++; if (rd_valid[1] !== 1'b1) begin failures++; $display("FAIL w2_rd_rdv got=%b exp=1", rd_valid[1]); end
        tick();
        checks++; if (rd_valid[1] !== 1'b0) begin failures++; $display("FAIL w2_rdv_drop got=%b exp=0", rd_valid[1]); end
    endtask

    task automatic test_hold_level();
        int pulses;
        // WAIT_CYCLES=0: strobe held for five edges.
        load_mar(0, 4'd3);
        ld_mdr[0] = 1'b1; we[0] = 1'b0;
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 4) ld_mdr[0] = 1'b0;
            if (rd_valid[0] === 1'b1) pulses++;
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL hold_w0_pulses got=%0d exp=1", pulses); end
        checks++; if (mdr[0] !== 8'hA5) begin failures++; $display("FAIL hold_w0_mdr got=%h exp=a5", mdr[0]); end
        // WAIT_CYCLES=2: the held level must not count as a new strobe.
        load_mar(1, 4'd8);
        ld_mdr[1] = 1'b1; we[1] = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 4) ld_mdr[1] = 1'b0;
            if (rd_valid[1] === 1'b1) pulses++;
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL hold_w2_pulses got=%0d exp=1", pulses); end
        checks++; if (mdr[1] !== 8'h77) begin failures++; $display("FAIL hold_w2_mdr got=%h exp=77", mdr[1]); end
        checks++; if (ovr[1] !== 1'b0) begin failures++; $display("FAIL hold_w2_ovr got=%b exp=0", ovr[1]); end
        checks++; if (busy[1] !== 1'b0) begin failures++; $display("FAIL hold_w2_busy got=%b exp=0", busy[1]); end
    endtask

    task automatic test_busy_ovr();
        int n; bit to; int pulses; int busy_seen;
        // WAIT_CYCLES=3: ld_mar during WAIT is dropped and flagged.
        load_mar(2, 4'd2);
        access(2, 1'b1, 8'h5E, n, to);
        checks++; if (to || n != 3) begin failures++; $display("FAIL w3_wr_busy got=%0d exp=3", n); end
        load_mar(2, 4'd5);
        access(2, 1'b1, 8'h6F, n, to);
        load_mar(2, 4'd2);
        ld_mdr[2] = 1'b1; we[2] = 1'b0;
        tick();
        ld_mdr[2] = 1'b0;
        ld_mar[2] = 1'b1; addr[2] = 4'd5;
        tick();
        ld_mar[2] = 1'b0;
        checks++; if (ovr[2] !== 1'b1) begin failures++; $display("FAIL ovr_mar_flag got=%b exp=1", ovr[2]); end
        checks++; if (mar[2] !== 4'd2) begin failures++; $display("FAIL ovr_mar_hold got=%h exp=2", mar[2]); end
        n = 0;
        while (busy[2] === 1'b1 && n < 40) begin n++; tick(); end
        checks++; if (n != 2) begin failures++; $display("FAIL ovr_busy_rest got=%0d exp=2", n); end
        checks++; if (mdr[2] !== 8'h5E) begin failures++; $display("FAIL ovr_mdr got=%h exp=5e", mdr[2]); end
        checks++; if (rd_valid[2] !== 1'b1) begin failures++; $display("FAIL ovr_rdv got=%b exp=1", rd_valid[2]); end
        tick();
        checks++; if (ovr[2] !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", ovr[2]); end
        // WAIT_CYCLES=2: a new ld_mdr rise during WAIT is flagged, not queued.
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        checks++; if (ovr[1] !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", ovr[1]); end
        load_mar(1, 4'd7);
        ld_mdr[1] = 1'b1; we[1] = 1'b0;
        tick();
        ld_mdr[1] = 1'b0;
        tick();
        ld_mdr[1] = 1'b1;
        tick();
        checks++; if (ovr[1] !== 1'b1) begin failures++; $display("FAIL ovr_mdr_flag got=%b exp=1", ovr[1]); end
        pulses = (rd_valid[1] === 1'b1) ? 1 : 0;
        busy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) ld_mdr[1] = 1'b0;
            tick();
            if (rd_valid[1] === 1'b1) pulses++;
            if (busy[1] === 1'b1) busy_seen++;
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL ovr_noqueue_pulses got=%0d exp=1", pulses); end
        checks++; if (busy_seen != 0) begin failures++; $display("FAIL ovr_noqueue_busy got=%0d exp=0", busy_seen); end
        checks++; if (mdr[1] !== 8'h3C) begin failures++; $display("FAIL ovr_noqueue_mdr got=%h exp=3c", mdr[1]); end
    endtask

    task automatic test_bypass();
        int n; bit to;
        load_mar(0, 4'd9);
        access(0, 1'b1, 8'h11, n, to);
        load_mar(0, 4'd1);
        access(0, 1'b1, 8'h22, n, to);
        tick();
        ld_mar[0] = 1'b1; addr[0] = 4'd9; ld_mdr[0] = 1'b1; we[0] = 1'b0;
        tick();
        ld_mar[0] = 1'b0; ld_mdr[0] = 1'b0;
        checks++; if (mdr[0] !== 8'h11) begin failures++; $display("FAIL byp_w0_mdr got=%h exp=11", mdr[0]); end
        checks++; if (mar[0] !== 4'd9) begin failures++; $display("FAIL byp_w0_mar got=%h exp=9", mar[0]); end
        checks++; if (rd_valid[0] !== 1'b1) begin failures++; $display("FAIL byp_w0_rdv got=%b exp=1", rd_valid[0]); end
        // Stretched access must latch the bypassed address.
        load_mar(1, 4'd7);
        ld_mar[1] = 1'b1; addr[1] = 4'd8; ld_mdr[1] = 1'b1; we[1] = 1'b0;
        tick();
        ld_mar[1] = 1'b0; ld_mdr[1] = 1'b0;
        n = 0;
        while (busy[1] === 1'b1 && n < 40) begin n++; tick(); end
        checks++; if (mdr[1] !== 8'h77) begin failures++; $display("FAIL byp_w2_mdr got=%h exp=77", mdr[1]); end
        checks++; if (mar[1] !== 4'd8) begin failures++; $display("FAIL byp_w2_mar got=%h exp=8", mar[1]); end
        tick();
    endtask

    task automatic test_reset_mid();
        int n; bit to; int busy_seen;
        load_mar(1, 4'd7);
        ld_mdr[1] = 1'b1; we[1] = 1'b1; wdata[1] = 8'h99;
        tick();
        ld_mdr[1] = 1'b0; we[1] = 1'b0;
        checks++; if (busy[1] !== 1'b1) begin failures++; $display("FAIL rstmid_busy_pre got=%b exp=1", busy[1]); end
        tick();
        // Reset lands on the edge that would have completed the write.
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        checks++; if (mdr[1] !== 8'h00) begin failures++; $display("FAIL rstmid_mdr got=%h exp=0", mdr[1]); end
        checks++; if (busy[1] !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy[1]); end
        checks++; if (mar[1] !== 4'd0) begin failures++; $display("FAIL rstmid_mar got=%h exp=0", mar[1]); end
        busy_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (busy[1] === 1'b1) busy_seen++;
        end
        checks++; if (busy_seen != 0) begin failures++; $display("FAIL rstmid_busy_after got=%0d exp=0", busy_seen); end
        load_mar(1, 4'd7);
        access(1, 1'b0, 8'h00, n, to);
        checks++; if (mdr[1] !== 8'h3C) begin failures++; $display("FAIL rstmid_ram got=%h exp=3c", mdr[1]); end
        tick();
    endtask

`ifdef MEM_PARITY_EN
    task automatic test_parity();
        int n; bit to;
        load_mar(0, 4'd4);
        access(0, 1'b1, 8'h01, n, to);
        load_mar(0, 4'd4);
        access(0, 1'b0, 8'h00, n, to);
        checks++; if (par_err[0] !== 1'b0) begin failures++; $display("FAIL par_clean got=%b exp=0", par_err[0]); end
        u_w0.r_par[4] = ~u_w0.r_par[4];
        load_mar(0, 4'd4);
        access(0, 1'b0, 8'h00, n, to);
        checks++; if (mdr[0] !== 8'h01) begin failures++; $display("FAIL par_mdr got=%h exp=01", mdr[0]); end
        checks++; if (par_err[0] !== 1'b1) begin failures++; $display("FAIL par_err got=%b exp=1", par_err[0]); end
        tick(); tick(); tick();
        checks++; if (par_err[0] !== 1'b1) begin failures++; $display("FAIL par_sticky got=%b exp=1", par_err[0]); end
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        checks++; if (par_err[0] !== 1'b0) begin failures++; $display("FAIL par_reset got=%b exp=0", par_err[0]); end
    endtask
`endif

    initial begin
        test_reset();
        test_read_w0();
        test_write_wait2();
        test_hold_level();
        test_busy_ovr();
        test_bypass();
        test_reset_mid();
`ifdef MEM_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
